fib_rr_scheduler: RTL and testbench
===================================

Name: fib_rr_scheduler

Overview:
- Shares one Fibonacci stepping engine between two requesters. Each requester asks for term F(n).
- A round-robin arbiter grants the engine to one requester. A Moore controller then loads the engine, steps it n times and returns F(n) tagged with the requester id.
- Sits between client logic and the Fibonacci datapath. It replaces the free-running generator wherever on-demand terms are needed.

Parameters:
WIDTH, 6, result width in bits; values wrap modulo 2^WIDTH
IDXW, 4, index width in bits; n ranges 0..2^IDXW-1

Ports:
clock  in  1  single system clock; all state changes on its rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0  in  1  requester 0 request, level-sensitive
idx0  in  IDXW  requester 0 term index n; stable while req0 is high
req1  in  1  requester 1 request, level-sensitive
idx1  in  IDXW  requester 1 term index n
gnt  out  2  one-hot grant; bit k high for the single LOAD cycle of requester k
busy  out  1  high whenever state != IDLE
rsp_valid  out  1  high for exactly one cycle (DONE state)
rsp_id  out  1  requester id of the current or last response
result  out  WIDTH  F(n) mod 2^WIDTH; held until the next DONE
overflow  out  1  high if true F(n) >= 2^WIDTH; held with result
state  out  2  debug: IDLE=0, LOAD=1, STEP=2, DONE=3

Behaviour:
- Reset (reset=0, asynchronous) forces: state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, result=0, overflow=0, last_grant=1 (so req0 wins first). An operation in flight is abandoned and no response is issued. Requests are sampled again from the first edge after reset releases.
- Definitions: F(0)=0, F(1)=1, F(k+2)=F(k+1)+F(k).
- IDLE:
  - Only one request high: that request wins.
  - Both requests high: the requester not equal to last_grant wins.
  - On the edge: latch the winner's idx into cnt and its id into cur_id; update last_grant; go to LOAD.
  - No request: stay in IDLE.
- LOAD (1 cycle):
  - gnt[cur_id]=1.
  - Engine: a<=0, b<=1, a_ovf<=0, b_ovf<=0.
  - Next state: DONE if cnt==0, else STEP.
- STEP (one cycle per iteration):
  - a<=b; b<=(a+b) mod 2^WIDTH; a_ovf<=b_ovf; b_ovf<=a_ovf|b_ovf|carry_out(a+b); cnt<=cnt-1.
  - Go to DONE when cnt==1 on this edge; otherwise stay.
  - Exactly n STEP cycles are spent.
- DONE (1 cycle):
  - rsp_valid=1, rsp_id=cur_id, result=a, overflow=a_ovf. result and overflow are registered on entry to DONE.
  - Next state: IDLE.
- Latency: the acceptance edge is E0; rsp_valid is high in the cycle following edge E(n+1). Total occupancy is n+2 cycles; IDLE then gives a re-arbitration opportunity.
- Requester rules:
  - If req is still high in the IDLE cycle after its response, it counts as a new request.
  - A request dropped before being granted is withdrawn without effect.
  - Requests arriving while busy wait; they are never lost while held.
- Round-robin starvation bound: a continuously held request is granted within one foreign transaction.
- idx changes after acceptance are ignored. Only the value latched in IDLE is used.
- gnt, busy, rsp_valid and state are decoded from the state register only (Moore, glitch-free). No combinational path from req/idx to any output.

Test Plan:
- Reset, then req0=1, idx0=9 held -> gnt=01 for 1 cycle, 9 STEP cycles, rsp_valid in cycle 11 after the acceptance edge with rsp_id=0, result=34, overflow=0.
- req1=1, idx1=10 -> result=55, overflow=0. Then idx1=11 -> result=25 (89 mod 64), overflow=1. Then idx1=15 -> result=34 (610 mod 64), overflow=1.
- req0=1, idx0=0 -> LOAD then DONE, no STEP; result=0, overflow=0, rsp_valid 2 cycles after acceptance. Repeat with idx0=1 -> result=1.
- Immediately after reset, req0 and req1 rise together (idx0=3, idx1=4) and are held -> first response rsp_id=0 result=2, second rsp_id=1 result=3. Keep both held -> grants alternate 0,1,0,1.
- Assert reset=0 mid-STEP (idx0=12) -> state=0, busy=0, rsp_valid=0, result=0 immediately, without waiting for a clock edge. After release with req1 high -> req1 granted first.
- Pulse req1 for 1 cycle while busy serving req0 -> no grant or response for requester 1. After req0's response, busy falls and state=IDLE.

Source files
------------

// File: rtl/fib_rr_scheduler.sv
// Shares one Fibonacci stepping engine between two requesters.
// Requests go through a round-robin arbiter, and each response is tagged with the requester id.
//
// state | meaning
// IDLE  | waiting for a request, arbitrates on the edge
// LOAD  | grant pulse, engine seeded with F(0), F(1)
// STEP  | one Fibonacci iteration per cycle, cnt counts down
// DONE  | rsp_valid pulse, result/overflow registered on entry
module fib_rr_scheduler #(
   parameter int WIDTH = 6,
   parameter int IDXW  = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0,
   input  logic [IDXW-1:0]  idx0,
   input  logic             req1,
   input  logic [IDXW-1:0]  idx1,
   output logic [1:0]       gnt,
   output logic             busy,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic [1:0]       state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_STEP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [IDXW-1:0]  CNT_ONE = 1;
   localparam logic [WIDTH-1:0] VAL_ONE = 1;

   logic [1:0]       state_q, state_d;
   logic [IDXW-1:0]  cnt_q, cnt_d;
   logic             cur_id_q, cur_id_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             overflow_q, overflow_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH:0]   sum;
   logic             win;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_id_d     = cur_id_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      a_ovf_d      = a_ovf_q;
      b_ovf_d      = b_ovf_q;
      result_d     = result_q;
      overflow_d   = overflow_q;
      rsp_id_d     = rsp_id_q;
      win          = 1'b0;
      sum          = {1'b0, a_q} + {1'b0, b_q};

      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // On contention the requester that was not served last wins
               win          = (req0 && req1) ? ~last_grant_q : req1;
               cnt_d        = win ? idx1 : idx0;
               cur_id_d     = win;
               last_grant_d = win;
               state_d      = S_LOAD;
            end
         end
         S_LOAD: begin
            a_d     = '0;
            b_d     = VAL_ONE;
            a_ovf_d = 1'b0;
            b_ovf_d = 1'b0;
            state_d = (cnt_q == '0) ? S_DONE : S_STEP;
         end
         S_STEP: begin
            a_d     = b_q;
            b_d     = sum[WIDTH-1:0];
            a_ovf_d = b_ovf_q;
            b_ovf_d = a_ovf_q | b_ovf_q | sum[WIDTH];
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Capture the engine's next 'a' so result lines up with the DONE cycle
      if (state_d == S_DONE && state_q != S_DONE) begin
         result_d   = a_d;
         overflow_d = a_ovf_d;
         rsp_id_d   = cur_id_q;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         a_ovf_q      <= 1'b0;
         b_ovf_q      <= 1'b0;
         result_q     <= '0;
         overflow_q   <= 1'b0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_id_q     <= cur_id_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         a_ovf_q      <= a_ovf_d;
         b_ovf_q      <= b_ovf_d;
         result_q     <= result_d;
         overflow_q   <= overflow_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign gnt       = (state_q == S_LOAD) ? (cur_id_q ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = (state_q != S_IDLE);
   assign rsp_valid = (state_q == S_DONE);
   assign rsp_id    = rsp_id_q;
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign state     = state_q;

endmodule

// File: tb/tb_fib_rr_scheduler.sv
// Directed bench for fib_rr_scheduler with hand-computed Fibonacci terms mod 64.
module tb_fib_rr_scheduler;

   logic       clock;
   logic       reset;
   logic       req0, req1;
   logic [3:0] idx0, idx1;
   logic [1:0] gnt;
   logic       busy, rsp_valid, rsp_id, overflow;
   logic [5:0] result;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   fib_rr_scheduler #(.WIDTH(6), .IDXW(4)) dut (
      .clock    (clock),
      .reset    (reset),
      .req0     (req0),
      .idx0     (idx0),
      .req1     (req1),
      .idx1     (idx1),
      .gnt      (gnt),
      .busy     (busy),
      .rsp_valid(rsp_valid),
      .rsp_id   (rsp_id),
      .result   (result),
      .overflow (overflow),
      .state    (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // One transaction from an idle scheduler: request at an IDLE negedge, drop it in DONE.
   task automatic do_txn(input bit id, input logic [3:0] n,
                         input logic [5:0] exp_res, input bit exp_ovf);
      int cyc, steps;
      logic [1:0] g;
      bit done;
      @(negedge clock);
      chk("idle_state", state, 0);
      chk("idle_busy", busy, 0);
      if (id) begin req1 = 1'b1; idx1 = n; end
      else    begin req0 = 1'b1; idx0 = n; end
      cyc = 0; steps = 0; g = 2'b00; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (cyc == 1) g = gnt;
         if (state == 2'd2) steps++;
         if (rsp_valid) done = 1;
      end
      if (id) req1 = 1'b0; else req0 = 1'b0;
      chk("rsp_seen", done, 1);
      chk("gnt", g, id ? 2 : 1);
      chk("latency", cyc, 32'(n) + 2);
      chk("steps", steps, 32'(n));
      chk("rsp_id", rsp_id, id);
      chk("result", result, exp_res);
      chk("overflow", overflow, exp_ovf);
   endtask

   initial begin
      int cyc, nrsp, ngnt;
      logic [1:0] gnt_log [4];
      logic       id_log  [4];
      logic [5:0] res_log [4];
      bit saw_g1, saw_r1, done;

      reset = 1'b1; req0 = 0; req1 = 0; idx0 = 0; idx1 = 0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_state", state, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_result", result, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_id", rsp_id, 0);
      reset = 1'b1;

      do_txn(0, 4'd9,  6'd34, 0);
      do_txn(1, 4'd10, 6'd55, 0);
      do_txn(1, 4'd11, 6'd25, 1);
      do_txn(1, 4'd15, 6'd34, 1);
      do_txn(0, 4'd0,  6'd0,  0);
      do_txn(0, 4'd1,  6'd1,  0);

      // Both requesters rise together right after reset and stay high
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      req0 = 1; idx0 = 4'd3; req1 = 1; idx1 = 4'd4;
      reset = 1'b1;
      nrsp = 0; ngnt = 0; cyc = 0;
      while (nrsp < 4 && cyc < 80) begin
         @(negedge clock);
         cyc++;
         if (gnt != 2'b00 && ngnt < 4) begin gnt_log[ngnt] = gnt; ngnt++; end
         if (rsp_valid) begin
            id_log[nrsp] = rsp_id; res_log[nrsp] = result; nrsp++;
         end
      end
      req0 = 0; req1 = 0;
      chk("rr_nrsp", nrsp, 4);
      chk("rr_ngnt", ngnt, 4);
      for (int i = 0; i < 4; i++) begin
         chk("rr_gnt", gnt_log[i], (i % 2 == 0) ? 1 : 2);
         chk("rr_id", id_log[i], (i % 2 == 0) ? 0 : 1);
         chk("rr_result", res_log[i], (i % 2 == 0) ? 2 : 3);
      end

      // Asynchronous reset in the middle of a long STEP run
      @(negedge clock);
      req0 = 1; idx0 = 4'd12;
      repeat (5) @(negedge clock);
      chk("pre_rst_state", state, 2);
      #2 reset = 1'b0;
      #1;
      chk("async_state", state, 0);
      chk("async_busy", busy, 0);
      chk("async_valid", rsp_valid, 0);
      chk("async_result", result, 0);
      chk("async_ovf", overflow, 0);
      req0 = 0;
      @(negedge clock);
      reset = 1'b1;
      do_txn(1, 4'd2, 6'd1, 0);

      // A one-cycle req1 pulse while req0 is being served must vanish
      @(negedge clock);
      req0 = 1; idx0 = 4'd5;
      cyc = 0; saw_g1 = 0; saw_r1 = 0; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clock);
         cyc++;
         if (cyc == 2) begin req1 = 1; idx1 = 4'd7; end
         if (cyc == 3) req1 = 0;
         if (gnt[1]) saw_g1 = 1;
         if (rsp_valid && rsp_id) saw_r1 = 1;
         if (rsp_valid) done = 1;
      end
      req0 = 0;
      chk("pulse_rsp_seen", done, 1);
      chk("pulse_result", result, 5);
      chk("pulse_id", rsp_id, 0);
      repeat (8) begin
         @(negedge clock);
         if (gnt[1]) saw_g1 = 1;
         if (rsp_valid) saw_r1 = 1;
      end
      chk("pulse_no_gnt1", saw_g1, 0);
      chk("pulse_no_rsp1", saw_r1, 0);
      chk("pulse_busy", busy, 0);
      chk("pulse_state", state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
